// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache with a blocking miss FSM
// (IDLE -> MEM_READ -> UPDATE) and saturating hit/miss statistics counters.
module instr_cache #(
    parameter int ADDR_W          = 10,
    parameter int NUM_SETS        = 8,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int CNT_W           = 16
) (
    input  logic                                           CLK,
    input  logic                                           RESET,
    input  logic                                           READ,
    input  logic [ADDR_W-1:0]                              PC_ADDR,
    output logic [31:0]                                    INSTRUCTION,
    output logic                                           BUSYWAIT,
    output logic                                           mem_READ,
    output logic [ADDR_W-3-$clog2(WORDS_PER_BLOCK):0]      mem_ADDRESS,
    input  logic [32*WORDS_PER_BLOCK-1:0]                  mem_READDATA,
    input  logic                                           mem_BUSYWAIT,
    output logic [CNT_W-1:0]                               HIT_COUNT,
    output logic [CNT_W-1:0]                               MISS_COUNT
);

    localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int BLK_W = ADDR_W - 2 - OFF_W;
    localparam int TAG_W = BLK_W - IDX_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;

    state_t                         state_r;
    state_t                         state_s;
    logic [NUM_SETS-1:0]            valid_r;
    logic [TAG_W-1:0]               tag_r  [NUM_SETS];
    logic [32*WORDS_PER_BLOCK-1:0]  data_r [NUM_SETS];
    logic [BLK_W-1:0]               blk_r;
    logic                           after_update_r;
    logic [CNT_W-1:0]               hit_cnt_r;
    logic [CNT_W-1:0]               miss_cnt_r;

    logic [OFF_W-1:0]               offset_s;
    logic [IDX_W-1:0]               index_s;
    logic [TAG_W-1:0]               tag_s;
    logic                           hit_s;
    logic [31:0]                    word_s;
    logic [31:0]                    instr_s;
    logic                           busy_s;
    logic                           mem_rd_s;
    logic                           miss_s;
    logic                           hit_inc_s;
    logic                           fill_s;

    assign offset_s = PC_ADDR[2 +: OFF_W];
    assign index_s  = PC_ADDR[2+OFF_W +: IDX_W];
    assign tag_s    = PC_ADDR[ADDR_W-1 -: TAG_W];
    assign hit_s    = valid_r[index_s] && (tag_r[index_s] == tag_s);
    assign word_s   = data_r[index_s][{offset_s, 5'b00000} +: 32];

    // Next-state and per-cycle control decode.
    always_comb begin
        state_s   = state_r;
        instr_s   = 32'h0000_0000;
        busy_s    = 1'b0;
        mem_rd_s  = 1'b0;
        miss_s    = 1'b0;
        hit_inc_s = 1'b0;
        fill_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (READ) begin
                    if (hit_s) begin
                        instr_s   = word_s;
                        // The re-access right after a fill is not a new hit.
                        hit_inc_s = !after_update_r;
                    end else begin
                        busy_s  = 1'b1;
                        miss_s  = 1'b1;
                        state_s = MEM_READ;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            MEM_READ: begin
                busy_s   = 1'b1;
                mem_rd_s = 1'b1;
                if (!mem_BUSYWAIT) begin
                    fill_s  = 1'b1;
                    state_s = UPDATE;
                end else begin
                    state_s = MEM_READ;
                end
            end
            UPDATE: begin
                busy_s  = 1'b1;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign INSTRUCTION = RESET ? 32'h0000_0000 : instr_s;
    assign BUSYWAIT    = RESET ? 1'b0 : busy_s;
    assign mem_READ    = RESET ? 1'b0 : mem_rd_s;
    assign mem_ADDRESS = blk_r;
    assign HIT_COUNT   = hit_cnt_r;
    assign MISS_COUNT  = miss_cnt_r;

    // Control state, valid bits, latched block address and statistics.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r        <= IDLE;
            valid_r        <= {NUM_SETS{1'b0}};
            blk_r          <= {BLK_W{1'b0}};
            after_update_r <= 1'b0;
            hit_cnt_r      <= {CNT_W{1'b0}};
            miss_cnt_r     <= {CNT_W{1'b0}};
        end else begin
            state_r        <= state_s;
            after_update_r <= (state_r == UPDATE);
            if (miss_s) begin
                blk_r <= PC_ADDR[ADDR_W-1 -: BLK_W];
            end
            if (fill_s) begin
                valid_r[blk_r[IDX_W-1:0]] <= 1'b1;
            end
            if (hit_inc_s && !(&hit_cnt_r)) begin
                hit_cnt_r <= hit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (miss_s && !(&miss_cnt_r)) begin
                miss_cnt_r <= miss_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Tag and data arrays need no reset; valid bits qualify them.
    always_ff @(posedge CLK) begin
        if (fill_s && !RESET) begin
            tag_r[blk_r[IDX_W-1:0]]  <= blk_r[BLK_W-1 -: TAG_W];
            data_r[blk_r[IDX_W-1:0]] <= mem_READDATA;
        end
    end

endmodule
